// File: rtl/dsram_port_arbiter.sv
// ============================================================================
//  Module   : dsram_port_arbiter
//  Purpose  : Shares the single-port data SRAM between the CPU memory stage
//             and a DMA/debug requester, with CPU priority and DMA anti-starvation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3,
  parameter int STALLCNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  cpurst,
  input  logic                  cpu_cs,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [3:0]            cpu_ben,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_stall,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [31:0]           dma_addr,
  input  logic [3:0]            dma_ben,
  input  logic [31:0]           dma_wdata,
  output logic                  dma_gnt,
  output logic [31:0]           dma_rdata,
  output logic                  dma_rvalid,
  output logic [31:0]           dsram_addr,
  output logic                  dsram_cs,
  output logic                  dsram_we,
  output logic [3:0]            dsram_ben,
  output logic [31:0]           dsram_wdata,
  input  logic [31:0]           dsram_rdata,
  output logic [STALLCNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [CNT_W-1:0] C_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      r_starve_cnt;
  owner_t                r_rd_owner;
  logic [STALLCNT_W-1:0] r_stall_cnt;

  logic w_force;
  logic w_dma_win;
  logic w_cs;

  assign w_force   = dma_req & (r_starve_cnt >= C_STARVE_LIMIT);
  assign w_dma_win = dma_req & (~cpu_cs | w_force);
  assign w_cs      = cpu_cs | dma_req;

  assign dma_gnt   = w_dma_win;
  assign cpu_stall = cpu_cs & w_dma_win;

  always_comb begin
    dsram_cs    = w_cs;
    dsram_addr  = cpu_addr;
    dsram_we    = cpu_we;
    dsram_ben   = cpu_ben;
    dsram_wdata = cpu_wdata;
    if (w_dma_win) begin
      dsram_addr  = dma_addr;
      dsram_we    = dma_we;
      dsram_ben   = dma_ben;
      dsram_wdata = dma_wdata;
    end
    // An idle macro must never see a stray write strobe.
    if (!w_cs) begin
      dsram_we  = 1'b0;
      dsram_ben = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      r_starve_cnt <= '0;
      r_rd_owner   <= OWN_NONE;
      r_stall_cnt  <= '0;
    end else begin
      if (dma_req && !w_dma_win) begin
        if (r_starve_cnt < C_STARVE_LIMIT)
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end else begin
        r_starve_cnt <= '0;
      end

      if (w_dma_win && !dma_we)
        r_rd_owner <= OWN_DMA;
      else if (cpu_cs && !cpu_we && !w_dma_win)
        r_rd_owner <= OWN_CPU;
      else
        r_rd_owner <= OWN_NONE;

      if (cpu_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + STALLCNT_W'(1);
    end
  end

  // Read data is shared; the owner tag decides which side sees it as valid.
  assign cpu_rdata  = dsram_rdata;
  assign dma_rdata  = dsram_rdata;
  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign dma_rvalid = (r_rd_owner == OWN_DMA);
  assign stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dsram_port_arbiter.sv
// ============================================================================
//  Module   : tb_dsram_port_arbiter
//  Purpose  : Self-checking bench for dsram_port_arbiter with an SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsram_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        cpu_cs, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_ben, dma_ben;
  logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata, dsram_addr, dsram_wdata;
  logic        dsram_cs, dsram_we;
  logic [3:0]  dsram_ben;
  logic [31:0] dsram_rdata;
  logic [15:0] stall_cnt;

  // Second instance with STARVE_LIMIT=0 sharing the same stimulus.
  logic        z_stall, z_rvalid, z_gnt, z_drvalid, z_cs, z_we;
  logic [31:0] z_rdata, z_drdata, z_addr, z_wdata;
  logic [3:0]  z_ben;
  logic [15:0] z_scnt;

  always #5 clk = ~clk;

  dsram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3), .STALLCNT_W(16)) u_dut (
    .clk(clk), .cpurst(cpurst),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ben(cpu_ben),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_ben(dma_ben),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid),
    .dsram_addr(dsram_addr), .dsram_cs(dsram_cs), .dsram_we(dsram_we),
    .dsram_ben(dsram_ben), .dsram_wdata(dsram_wdata), .dsram_rdata(dsram_rdata),
    .stall_cnt(stall_cnt)
  );

  dsram_port_arbiter #(.STARVE_LIMIT(0), .CNT_W(3), .STALLCNT_W(16)) u_dut_lim0 (
    .clk(clk), .cpurst(cpurst),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ben(cpu_ben),
    .cpu_wdata(cpu_wdata), .cpu_stall(z_stall), .cpu_rdata(z_rdata),
    .cpu_rvalid(z_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_ben(dma_ben),
    .dma_wdata(dma_wdata), .dma_gnt(z_gnt), .dma_rdata(z_drdata),
    .dma_rvalid(z_drvalid),
    .dsram_addr(z_addr), .dsram_cs(z_cs), .dsram_we(z_we),
    .dsram_ben(z_ben), .dsram_wdata(z_wdata), .dsram_rdata(dsram_rdata),
    .stall_cnt(z_scnt)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hDEADBEEF + 32'(i) * 32'h01010101;
  endfunction

  // Behavioural SRAM macro driven by the main DUT.
  logic [31:0] sram [16];
  always @(posedge clk) begin
    if (cpurst) begin
      for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
    end else if (dsram_cs) begin
      if (dsram_we) begin
        for (int b = 0; b < 4; b++)
          if (dsram_ben[b]) sram[dsram_addr[5:2]][8*b +: 8] <= dsram_wdata[8*b +: 8];
      end else begin
        dsram_rdata <= sram[dsram_addr[5:2]];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory image, consecutive DMA losses, pending read owner.
  logic [31:0] ref_mem [16];
  int          lost;
  int          exp_own;   // 0 none, 1 cpu, 2 dma
  logic [31:0] exp_data;
  int          exp_stall;
  logic        obs_gnt;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    lost = 0; exp_own = 0; exp_data = '0; exp_stall = 0;
  endtask

  task automatic step();
    logic        win, cs, we;
    logic [31:0] a, wd;
    logic [3:0]  be;
    #1;
    win = dma_req && (!cpu_cs || lost >= STARVE_LIMIT);
    cs  = cpu_cs || dma_req;
    a   = win ? dma_addr  : cpu_addr;
    wd  = win ? dma_wdata : cpu_wdata;
    we  = cs && (win ? dma_we : cpu_we);
    be  = cs ? (win ? dma_ben : cpu_ben) : 4'h0;
    obs_gnt = dma_gnt;
    check_eq("gnt", {31'd0, dma_gnt}, {31'd0, win});
    check_eq("stall", {31'd0, cpu_stall}, {31'd0, cpu_cs && win});
    check_eq("cs", {31'd0, dsram_cs}, {31'd0, cs});
    check_eq("we", {31'd0, dsram_we}, {31'd0, we});
    check_eq("ben", {28'd0, dsram_ben}, {28'd0, be});
    if (cs) check_eq("addr", dsram_addr, a);
    if (we) check_eq("wdata", dsram_wdata, wd);
    check_eq("lim0_gnt", {31'd0, z_gnt}, {31'd0, dma_req});
    check_eq("lim0_stall", {31'd0, z_stall}, {31'd0, cpu_cs && dma_req});

    exp_own = 0;
    if (cs && !we) begin
      exp_own  = win ? 2 : 1;
      exp_data = ref_mem[a[5:2]];
    end
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
    lost = (dma_req && !win) ? lost + 1 : 0;
    if (cpu_cs && win && exp_stall < 65535) exp_stall++;

    @(posedge clk); #1;
    check_eq("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_own == 1});
    check_eq("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, exp_own == 2});
    if (exp_own == 1) check_eq("cpu_rdata", cpu_rdata, exp_data);
    if (exp_own == 2) check_eq("dma_rdata", dma_rdata, exp_data);
    check_eq("stall_cnt", {16'd0, stall_cnt}, 32'(exp_stall));
  endtask

  task automatic drive(input logic cc, input logic cw, input logic [31:0] ca,
                       input logic [3:0] cb, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [3:0] db, input logic [31:0] dd);
    @(negedge clk);
    cpu_cs = cc; cpu_we = cw; cpu_addr = ca; cpu_ben = cb; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_ben = db; dma_wdata = dd;
    step();
  endtask

  initial begin
    cpurst = 1'b1;
    cpu_cs = 0; cpu_we = 0; cpu_addr = 0; cpu_ben = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_ben = 0; dma_wdata = 0;
    model_reset();
    #1;
    check_eq("rst_cs", {31'd0, dsram_cs}, 32'd0);
    check_eq("rst_gnt", {31'd0, dma_gnt}, 32'd0);
    check_eq("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check_eq("rst_crv", {31'd0, cpu_rvalid}, 32'd0);
    check_eq("rst_drv", {31'd0, dma_rvalid}, 32'd0);
    check_eq("rst_scnt", {16'd0, stall_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) cpurst = 1'b0;

    // CPU read of 0x100, SRAM holds 0xDEADBEEF there.
    drive(1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 0, 0);
    check_eq("t1_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check_eq("t1_rdata", cpu_rdata, 32'hDEADBEEF);

    // DMA write with the CPU idle.
    drive(0, 0, 0, 0, 0, 1, 1, 32'h200, 4'hF, 32'h12345678);
    check_eq("t2_gnt", {31'd0, obs_gnt}, 32'd1);
    check_eq("t2_norv", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);

    // Alternating owners on back-to-back reads.
    drive(1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h20, 4'hF, 0);
    check_eq("t3_drdata", dma_rdata, init_word(8));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Continuous contention: forced grant in cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h44, 4'hF, 0, 1, 0, 32'h48, 4'hF, 0);
      check_eq("starve_gnt", {31'd0, obs_gnt}, {31'd0, i == 4 || i == 9});
    end
    check_eq("starve_scnt", {16'd0, stall_cnt}, 32'd2);

    // Reset arriving after a CPU read is accepted, before the clock edge.
    @(negedge clk);
    cpu_cs = 1; cpu_we = 0; cpu_addr = 32'h30; dma_req = 0;
    #2 cpurst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_rv", {31'd0, cpu_rvalid}, 32'd0);
    check_eq("rst_mid_scnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk) cpurst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h4, 4'h3, 32'hCAFE0000 + i, 1, 0, 32'h8, 4'hF, 0);
      check_eq("rst_starve", {31'd0, obs_gnt}, {31'd0, i == 4});
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            $urandom & 32'h3FC, 4'($urandom), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            $urandom & 32'h3FC, 4'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
